// File: rtl/somador_acumulador_ctrl.sv
// ---------------------------------------------------------------------------
// somador_acumulador_ctrl
//
// Sequencing stage that sits in front of a combinational N_BITS signed adder.
// It accepts a stream of signed operands over a valid/ready handshake. It
// presents the running accumulator and the incoming operand to the adder, then
// captures the adder's sum back into the accumulator. On the last beat it
// publishes the final sum, the adder's Z/N/P flags, a sticky signed-overflow
// flag and the number of accepted operands.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 pulse: clear and begin a new accumulation
//   in_valid/in_ready     operand handshake (in_ready depends on state only)
//   in_data, in_last      signed operand and end-of-sequence marker
//   a_o, b_o              adder operands (accumulator, incoming operand)
//   s_i, z_i, n_i, p_i    adder sum and flags, same cycle
//   acc, count, ovf       running sum, accepted-operand count, sticky overflow
//   sum_valid             one-cycle pulse when the final result is published
//   z_o, n_o, p_o         adder flags captured on the last beat
//   busy                  high while accumulating
// ---------------------------------------------------------------------------
module somador_acumulador_ctrl #(
    parameter int N_BITS = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_BITS-1:0] in_data,
    input  logic              in_last,
    output logic [N_BITS-1:0] a_o,
    output logic [N_BITS-1:0] b_o,
    input  logic [N_BITS-1:0] s_i,
    input  logic              z_i,
    input  logic              n_i,
    input  logic              p_i,
    output logic [N_BITS-1:0] acc,
    output logic [CNT_W-1:0]  count,
    output logic              ovf,
    output logic              sum_valid,
    output logic              z_o,
    output logic              n_o,
    output logic              p_o,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int               MSB     = N_BITS - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    logic [N_BITS-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              z_q, z_d;
    logic              n_q, n_d;
    logic              p_q, p_d;

    logic              beat_ovf;

    // Signed overflow of this beat: both addends share a sign and the sum's
    // sign differs from it.
    assign beat_ovf = (acc_q[MSB] == in_data[MSB]) && (s_i[MSB] != acc_q[MSB]);

    // Handshake and status outputs are pure state decodes, so in_ready never
    // depends combinationally on in_valid.
    assign in_ready  = (state_q == ACCUM);
    assign busy      = (state_q == ACCUM);
    assign sum_valid = (state_q == DONE);

    assign a_o   = acc_q;
    assign b_o   = in_data;
    assign acc   = acc_q;
    assign count = count_q;
    assign ovf   = ovf_q;
    assign z_o   = z_q;
    assign n_o   = n_q;
    assign p_o   = p_q;

    // Next-state and datapath update. A start always wins over a beat in the
    // same cycle, so a restart discards the simultaneous operand.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        z_d     = z_q;
        n_d     = n_q;
        p_d     = p_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            ACCUM: begin
                if (start) begin
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end else if (in_valid) begin
                    acc_d   = s_i;
                    count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
                    ovf_d   = ovf_q | beat_ovf;
                    if (in_last) begin
                        z_d     = z_i;
                        n_d     = n_i;
                        p_d     = p_i;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset discards any sequence in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            p_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            z_q     <= z_d;
            n_q     <= n_d;
            p_q     <= p_d;
        end
    end

endmodule

// File: tb/tb_somador_acumulador_ctrl.sv
// ---------------------------------------------------------------------------
// tb_somador_acumulador_ctrl
//
// Self-checking bench for somador_acumulador_ctrl. The external adder is
// modelled here: S = A + B, Z = (S == 0), N = sign of S, P = S is even.
// Inputs change 1 ns after a rising edge and outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_somador_acumulador_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic [7:0] a_o;
    logic [7:0] b_o;
    logic [7:0] s_i;
    logic       z_i;
    logic       n_i;
    logic       p_i;
    logic [7:0] acc;
    logic [7:0] count;
    logic       ovf;
    logic       sum_valid;
    logic       z_o;
    logic       n_o;
    logic       p_o;
    logic       busy;

    int checks;
    int failures;

    somador_acumulador_ctrl #(
        .N_BITS(8),
        .CNT_W (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .a_o      (a_o),
        .b_o      (b_o),
        .s_i      (s_i),
        .z_i      (z_i),
        .n_i      (n_i),
        .p_i      (p_i),
        .acc      (acc),
        .count    (count),
        .ovf      (ovf),
        .sum_valid(sum_valid),
        .z_o      (z_o),
        .n_o      (n_o),
        .p_o      (p_o),
        .busy     (busy)
    );

    // Behavioural stand-in for the combinational adder.
    assign s_i = a_o + b_o;
    assign z_i = (s_i == 8'd0);
    assign n_i = s_i[7];
    assign p_i = ~s_i[0];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] op1;
        logic [7:0] op2;
        int         gap;
        logic [7:0] exp_acc;
        bit         exp_ovf;
        bit         exp_z;
        bit         exp_n;
        bit         exp_p;
    } vec_t;

    vec_t vecs[5];

    // Drive one cycle of inputs and advance to 1 ns after the next edge.
    task automatic applyStimulus(input logic st, input logic vld,
                                 input logic [7:0] data, input logic last);
        start    = st;
        in_valid = vld;
        in_data  = data;
        in_last  = last;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Full result check used at the DONE cycle.
    task automatic checkResult(input string tag, input logic [7:0] e_acc, input int e_cnt,
                               input bit e_ovf, input bit e_z, input bit e_n, input bit e_p);
        checkOutput({tag, ".sum_valid"}, int'(sum_valid), 1);
        checkOutput({tag, ".in_ready"},  int'(in_ready),  0);
        checkOutput({tag, ".acc"},       int'(acc),       int'(e_acc));
        checkOutput({tag, ".count"},     int'(count),     e_cnt);
        checkOutput({tag, ".ovf"},       int'(ovf),       int'(e_ovf));
        checkOutput({tag, ".z_o"},       int'(z_o),       int'(e_z));
        checkOutput({tag, ".n_o"},       int'(n_o),       int'(e_n));
        checkOutput({tag, ".p_o"},       int'(p_o),       int'(e_p));
    endtask

    // Reference model state for random sequences, kept as plain integers.
    int m_acc;
    int m_cnt;
    bit m_ovf;

    task automatic modelBeat(input logic [7:0] d);
        int sum;
        sum = m_acc + int'($signed(d));
        if (sum > 127 || sum < -128) m_ovf = 1'b1;
        while (sum > 127)  sum -= 256;
        while (sum < -128) sum += 256;
        m_acc = sum;
        if (m_cnt < 255) m_cnt++;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        in_last  = 1'b0;

        vecs[0] = '{8'd100, 8'd50,  0, 8'h96, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{8'd5,   8'hFB,  0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{8'h80,  8'hFF,  3, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'h9C,  8'hCE,  0, 8'h6A, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'd127, 8'd0,   1, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state
        #3;
        checkOutput("rst.acc",       int'(acc),       0);
        checkOutput("rst.count",     int'(count),     0);
        checkOutput("rst.ovf",       int'(ovf),       0);
        checkOutput("rst.sum_valid", int'(sum_valid), 0);
        checkOutput("rst.busy",      int'(busy),      0);
        checkOutput("rst.in_ready",  int'(in_ready),  0);
        checkOutput("rst.flags",     int'({z_o, n_o, p_o}), 0);
        #5;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Two-operand vectors
        for (int v = 0; v < 5; v++) begin
            applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
            checkOutput("vec.start_busy", int'(busy), 1);
            checkOutput("vec.start_acc",  int'(acc),  0);
            applyStimulus(1'b0, 1'b1, vecs[v].op1, 1'b0);
            checkOutput("vec.acc1", int'(acc), int'(vecs[v].op1));
            for (int g = 0; g < vecs[v].gap; g++) begin
                applyStimulus(1'b0, 1'b0, 8'h55, 1'b1);
                checkOutput("vec.gap_acc", int'(acc), int'(vecs[v].op1));
            end
            applyStimulus(1'b0, 1'b1, vecs[v].op2, 1'b1);
            checkResult("vec", vecs[v].exp_acc, 2, vecs[v].exp_ovf,
                        vecs[v].exp_z, vecs[v].exp_n, vecs[v].exp_p);
            applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
            checkOutput("vec.pulse_end", int'(sum_valid), 0);
            checkOutput("vec.hold_acc",  int'(acc), int'(vecs[v].exp_acc));
        end

        // Restart while accumulating, then ignored input in IDLE
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'd10, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'd20, 1'b0);
        checkOutput("rs.acc30", int'(acc), 30);
        applyStimulus(1'b1, 1'b1, 8'd7, 1'b0);
        checkOutput("rs.acc0",   int'(acc),   0);
        checkOutput("rs.count0", int'(count), 0);
        checkOutput("rs.busy",   int'(busy),  1);
        applyStimulus(1'b0, 1'b1, 8'd3, 1'b1);
        checkResult("rs", 8'd3, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'd55, 1'b1);
        checkOutput("idle.acc",       int'(acc),       3);
        checkOutput("idle.count",     int'(count),     1);
        checkOutput("idle.sum_valid", int'(sum_valid), 0);
        checkOutput("idle.busy",      int'(busy),      0);

        // Saturating count and back-to-back start during DONE
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        for (int i = 1; i <= 300; i++) begin
            applyStimulus(1'b0, 1'b1, 8'd1, (i == 300));
        end
        checkResult("sat", 8'd44, 255, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        checkOutput("b2b.busy",  int'(busy),  1);
        checkOutput("b2b.acc",   int'(acc),   0);
        checkOutput("b2b.count", int'(count), 0);
        checkOutput("b2b.ovf",   int'(ovf),   0);

        // Random sequences against the integer model
        for (int s = 0; s < 25; s++) begin
            int len;
            logic [7:0] d;
            logic [7:0] e_acc;
            bit e_z, e_n, e_p;
            len   = int'($urandom_range(1, 12));
            m_acc = 0;
            m_cnt = 0;
            m_ovf = 1'b0;
            applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
            for (int b = 1; b <= len; b++) begin
                int gap;
                gap = int'($urandom_range(0, 2));
                for (int g = 0; g < gap; g++) begin
                    applyStimulus(1'b0, 1'b0, 8'($urandom), 1'($urandom));
                end
                d = 8'($urandom);
                in_data = d;
                #1;
                checkOutput("rnd.b_o", int'(b_o), int'(d));
                checkOutput("rnd.a_o", int'(a_o), m_acc & 255);
                modelBeat(d);
                applyStimulus(1'b0, 1'b1, d, (b == len));
                checkOutput("rnd.acc",   int'(acc),   m_acc & 255);
                checkOutput("rnd.count", int'(count), m_cnt);
            end
            e_acc = 8'(m_acc);
            e_z   = (m_acc == 0);
            e_n   = (m_acc < 0);
            e_p   = ((m_acc % 2) == 0);
            checkResult("rnd", e_acc, m_cnt, m_ovf, e_z, e_n, e_p);
            applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        end

        // Asynchronous reset in the middle of a sequence
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'd9, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'd9, 1'b0);
        checkOutput("mid.acc18", int'(acc), 18);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid.acc",   int'(acc),   0);
        checkOutput("mid.count", int'(count), 0);
        checkOutput("mid.ovf",   int'(ovf),   0);
        checkOutput("mid.flags", int'({z_o, n_o, p_o}), 0);
        checkOutput("mid.busy",  int'(busy),  0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 8'd5, 1'b1);
            checkOutput("mid.no_sum", int'(sum_valid), 0);
            checkOutput("mid.acc_hold", int'(acc), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
